// File: rtl/clock_divider.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// clock_divider
//
// Programmable integer clock divider. Produces a registered divided clock
// (clkOut) and a one-cycle enable strobe (tick) per output period from clkIn.
// The divisor is reloaded at run time through a load/ack handshake. A new
// divisor only takes effect on a period boundary, so clkOut never glitches.
// Downstream logic should use tick as a clock enable rather than clocking
// from clkOut.
//
// Parameters:
//   WIDTH        width of the divisor and of the phase counter
//   DEFAULT_DIV  divisor after reset (>= 2, < 2**WIDTH)
//
// Ports:
//   clkIn    in   system clock, all state changes on posedge
//   reset    in   asynchronous, active-high reset
//   enable   in   1 = counter advances, 0 = freeze
//   divLoad  in   request to load divIn as the new divisor (sampled every cycle)
//   divIn    in   WIDTH-bit divisor accompanying divLoad (0/1 clamp to 2)
//   restart  in   (CLKDIV_RESTART_EN only) realign phase, next enabled cycle wraps
//   divBusy  out  a captured divisor is pending, not yet applied
//   divAck   out  one-cycle pulse in the cycle the pending divisor becomes active
//   clkOut   out  divided clock, registered
//   tick     out  one-cycle pulse at each clkOut rising edge, registered
//
// Optional feature macro: CLKDIV_RESTART_EN (adds the restart input).
// ---------------------------------------------------------------------------
module clock_divider #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clkIn,
    input  logic             reset,
    input  logic             enable,
    input  logic             divLoad,
    input  logic [WIDTH-1:0] divIn,
`ifdef CLKDIV_RESTART_EN
    input  logic             restart,
`endif
    output logic             divBusy,
    output logic             divAck,
    output logic             clkOut,
    output logic             tick
);

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] CNT_RST = WIDTH'(DEFAULT_DIV - 1);
    localparam logic [WIDTH-1:0] DIV_MIN = WIDTH'(2);

    logic [WIDTH-1:0] div;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] pend;
    logic             pendValid;

    logic [WIDTH-1:0] divNext;
    logic [WIDTH-1:0] cntNext;
    logic [WIDTH-1:0] pendNext;
    logic             pendValidNext;
    logic             clkOutNext;
    logic             tickNext;
    logic             divAckNext;

    logic [WIDTH-1:0] divClamped;
    logic [WIDTH-1:0] divApplied;
    logic [WIDTH-1:0] hi;
    logic [WIDTH:0]   cntInc;
    logic             wrap;
    logic             restartReq;

`ifdef CLKDIV_RESTART_EN
    assign restartReq = restart;
`else
    assign restartReq = 1'b0;
`endif

    // Divisors below 2 cannot produce a square wave; treat them as 2.
    assign divClamped = (divIn < DIV_MIN) ? DIV_MIN : divIn;
    assign divApplied = pendValid ? pend : div;
    assign hi         = div >> 1;
    // One extra bit so the increment/compare never wraps, even at div = 2**WIDTH-1.
    assign cntInc     = {1'b0, cnt} + {{WIDTH{1'b0}}, 1'b1};
    assign wrap       = enable && (cnt == (div - 1'b1));

    always_comb begin
        divNext       = div;
        cntNext       = cnt;
        pendNext      = pend;
        pendValidNext = pendValid;
        clkOutNext    = clkOut;
        tickNext      = 1'b0;
        divAckNext    = 1'b0;

        if (restartReq) begin
            // Park the counter on the last phase so the next enabled cycle wraps.
            divNext       = divApplied;
            cntNext       = divApplied - 1'b1;
            clkOutNext    = 1'b0;
            divAckNext    = pendValid;
            pendValidNext = 1'b0;
        end else if (wrap) begin
            cntNext    = '0;
            clkOutNext = 1'b1;
            tickNext   = 1'b1;
            if (pendValid) begin
                divNext       = pend;
                pendValidNext = 1'b0;
                divAckNext    = 1'b1;
            end
        end else if (enable) begin
            cntNext    = cntInc[WIDTH-1:0];
            clkOutNext = (cntInc < {1'b0, hi});
        end

        // A load in the same cycle as an apply is captured for the next
        // boundary; it never takes effect on the boundary it arrives in.
        if (divLoad) begin
            pendNext      = divClamped;
            pendValidNext = 1'b1;
        end
    end

    always_ff @(posedge clkIn or posedge reset) begin
        if (reset) begin
            div       <= DIV_RST;
            cnt       <= CNT_RST;
            pend      <= '0;
            pendValid <= 1'b0;
            clkOut    <= 1'b0;
            tick      <= 1'b0;
            divAck    <= 1'b0;
        end else begin
            div       <= divNext;
            cnt       <= cntNext;
            pend      <= pendNext;
            pendValid <= pendValidNext;
            clkOut    <= clkOutNext;
            tick      <= tickNext;
            divAck    <= divAckNext;
        end
    end

    assign divBusy = pendValid;

endmodule

// File: tb/tb_clock_divider.sv
`timescale 1ns/1ps
module tb_clock_divider;

    localparam int WIDTH = 16;

    logic             clkIn = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic             divLoad = 1'b0;
    logic [WIDTH-1:0] divIn = '0;
    logic             restart = 1'b0;
    logic             divBusy;
    logic             divAck;
    logic             clkOut;
    logic             tick;

    clock_divider #(.WIDTH(WIDTH), .DEFAULT_DIV(4)) dut (
        .clkIn   (clkIn),
        .reset   (reset),
        .enable  (enable),
        .divLoad (divLoad),
        .divIn   (divIn),
`ifdef CLKDIV_RESTART_EN
        .restart (restart),
`endif
        .divBusy (divBusy),
        .divAck  (divAck),
        .clkOut  (clkOut),
        .tick    (tick)
    );

    always #5 clkIn = ~clkIn;

    typedef struct {
        logic [3:0] v;      // {clkOut, tick, divBusy, divAck}
        string      tag;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference: position within the output period plus the pending divisor.
    int   mDiv, mPhase, mPend;
    logic mPendV, mClk;

    task automatic modelReset();
        mDiv = 4; mPhase = 3; mPend = 0; mPendV = 1'b0; mClk = 1'b0;
    endtask

    task automatic modelStep(input string tag);
        exp_t e;
        logic ack, tk;
        int   nd;
        ack = 1'b0; tk = 1'b0;
        if (restart) begin
            nd = mPendV ? mPend : mDiv;
            ack = mPendV; mPendV = 1'b0;
            mDiv = nd; mPhase = nd - 1; mClk = 1'b0;
        end else if (enable && mPhase == mDiv - 1) begin
            ack = mPendV;
            if (mPendV) mDiv = mPend;
            mPendV = 1'b0; mPhase = 0; mClk = 1'b1; tk = 1'b1;
        end else if (enable) begin
            mPhase = mPhase + 1;
            mClk = (mPhase < mDiv / 2);
        end
        if (divLoad) begin
            mPend = (divIn < 2) ? 2 : int'(divIn);
            mPendV = 1'b1;
        end
        e.v = {mClk, tk, mPendV, ack};
        e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s cyc=%0d got={clk,tick,busy,ack}=%b want=%b", tag, cyc, got, want);
        end
    endtask

    task automatic step(input string tag);
        exp_t e;
        modelStep(tag);
        @(posedge clkIn);
        #1;
        cyc++;
        e = sbq.pop_front();
        check(e.tag, {clkOut, tick, divBusy, divAck}, e.v);
    endtask

    task automatic runN(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    // Step until the reference sits at the given phase (bounded).
    task automatic stepToPhase(input int ph, input string tag);
        for (int i = 0; i < 64 && mPhase != ph; i++) step(tag);
        total++;
        assert (mPhase == ph) else begin
            bad++;
            $error("FAIL %s phase not reached got=%0d want=%0d", tag, mPhase, ph);
        end
    endtask

    initial begin
        modelReset();
        #12;
        check("reset_outputs", {clkOut, tick, divBusy, divAck}, 4'b0000);
        total++;
        assert (dut.div === 16'd4) else begin
            bad++; $error("FAIL reset_div got=%0d want=4", dut.div);
        end

        // Release reset (away from the edge) and run at the default divisor.
        @(posedge clkIn); #1;
        reset = 1'b0;
        enable = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step("default_div4");
            total++;
            assert (tick === ((c % 4) == 1)) else begin
                bad++; $error("FAIL tick_at_1_5_9 cyc=%0d got=%b want=%b", c, tick, (c % 4) == 1);
            end
        end

        // Now cnt = 1: load 5 mid-period.
        divLoad = 1'b1; divIn = 16'd5;
        step("load5_capture");
        divLoad = 1'b0;
        runN(14, "div5_period");

        // divIn = 0 clamps to 2.
        stepToPhase(1, "seek_before_load0");
        divLoad = 1'b1; divIn = 16'd0;
        step("load0_capture");
        divLoad = 1'b0;
        runN(10, "div2_period");

        // Two loads before a wrap: last one wins, single ack.
        divLoad = 1'b1; divIn = 16'd6;
        step("load6");
        divLoad = 1'b1; divIn = 16'd3;
        step("load3_overwrite");
        divLoad = 1'b0;
        runN(10, "div3_period");

        // Load exactly on the wrap cycle: not applied on that wrap.
        stepToPhase(2, "seek_wrap");
        divLoad = 1'b1; divIn = 16'd7;
        step("load_on_wrap");
        divLoad = 1'b0;
        check("no_ack_on_wrap", {tick, divAck}, 2'b10);
        runN(16, "div7_after_wrap");

        // Freeze for 3 cycles at cnt = 2.
        stepToPhase(2, "seek_cnt2");
        enable = 1'b0;
        runN(3, "frozen");
        enable = 1'b1;
        runN(12, "resume");

        // Async reset in the middle of a pending load.
        divLoad = 1'b1; divIn = 16'd9;
        step("load9_before_reset");
        divLoad = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("reset_midload_async", {clkOut, tick, divBusy, divAck}, 4'b0000);
        total++;
        assert (dut.div === 16'd4) else begin
            bad++; $error("FAIL reset_midload_div got=%0d want=4", dut.div);
        end
        sbq.delete();
        modelReset();
        @(posedge clkIn); #1;
        check("reset_held", {clkOut, tick, divBusy, divAck}, 4'b0000);
        reset = 1'b0;
        runN(9, "post_reset_div4");

`ifdef CLKDIV_RESTART_EN
        // Restart at cnt = 2 with a pending divisor: applied immediately.
        stepToPhase(2, "seek_restart");
        divLoad = 1'b1; divIn = 16'd5;
        step("load5_before_restart");
        divLoad = 1'b0;
        restart = 1'b1;
        step("restart_pulse");
        restart = 1'b0;
        check("restart_ack", {tick, divAck}, 2'b01);
        step("restart_next_wrap");
        check("restart_tick", tick, 1'b1);
        runN(10, "after_restart");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
